ptw_miss_arbiter: RTL and testbench
===================================

Name: ptw_miss_arbiter

Overview:
- Shares the single page-table walker between the instruction TLB and the data TLB.
- Accepts held miss requests from both sources, arbitrates round-robin, and latches the winner's vaddr/ASID/store flag.
- Issues one walk request to the walker, then routes its completion (TLB update, page fault, PMP access fault) back to the originating TLB as a one-cycle done pulse.
- Handles flush by draining the in-flight walk, and bounds each walk with a timeout.

Parameters:
- VLEN, 39, virtual address width.
- ASID_WIDTH, 16, ASID width.
- TIMEOUT_CYCLES, 1024, maximum cycles in WALK before a forced access-fault completion; must be ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock; synchronous, active-high
- flush_i  in  1  pipeline flush
- itlb_miss_i  in  1  ITLB miss; held high until itlb_done_o or flush
- itlb_vaddr_i  in  VLEN  ITLB miss vaddr
- dtlb_miss_i  in  1  DTLB miss; held high until dtlb_done_o or flush
- dtlb_vaddr_i  in  VLEN  DTLB miss vaddr
- dtlb_is_store_i  in  1  DTLB miss caused by a store
- asid_i  in  ASID_WIDTH  current ASID
- ptw_req_o  out  1  one-cycle walk request to the walker
- ptw_vaddr_o  out  VLEN  latched vaddr
- ptw_asid_o  out  ASID_WIDTH  latched ASID
- ptw_is_instr_o  out  1  latched grant is ITLB
- ptw_is_store_o  out  1  latched store flag (0 for ITLB)
- ptw_active_i  in  1  walker busy
- ptw_update_valid_i  in  1  walker produced a TLB update
- ptw_error_i  in  1  walker page fault
- ptw_access_exception_i  in  1  walker PMP access fault
- itlb_done_o  out  1  ITLB completion pulse
- dtlb_done_o  out  1  DTLB completion pulse
- resp_page_fault_o  out  1  valid with a done pulse
- resp_access_fault_o  out  1  valid with a done pulse
- timeout_o  out  1  sticky; set on any timeout, cleared only by reset
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - All outputs are 0.
  - Latched vaddr/ASID/flags are 0.
  - Round-robin pointer is last_grant = DTLB, so ITLB wins the first tie.
  - Reset mid-walk drops everything; no done pulse is issued.
- Internal FSM states: IDLE, ISSUE, WAIT_START, WALK, RESPOND, DRAIN.
- IDLE:
  - If flush_i is high, there is no grant.
  - Otherwise, if either miss is high, grant it.
  - If both are high, grant the source opposite last_grant.
  - On grant: latch vaddr, asid_i, is_instr, and is_store (dtlb_is_store_i for DTLB, 0 for ITLB); update last_grant; go to ISSUE.
- ISSUE:
  - ptw_req_o = 1 for exactly this cycle; go to WAIT_START.
  - Latency from a miss seen in IDLE at cycle N to ptw_req_o is cycle N+1.
- WAIT_START:
  - Wait for ptw_active_i = 1, then go to WALK.
  - If a completion input arrives in the same cycle as ptw_active_i, treat it as in WALK.
- WALK:
  - The timeout counter increments each cycle.
  - On ptw_update_valid_i, ptw_error_i, or ptw_access_exception_i, go to RESPOND.
    - Latch page_fault = ptw_error_i.
    - Latch access_fault = ptw_access_exception_i.
    - If several completion inputs are high together: access fault takes priority and page_fault is cleared.
  - If the counter reaches TIMEOUT_CYCLES-1 with no completion:
    - Set timeout_o.
    - Go to RESPOND with access_fault = 1.
    - After RESPOND, go to DRAIN instead of IDLE.
- RESPOND:
  - Pulse the done output of the granted source for one cycle, with resp_* valid.
  - Next state is IDLE, or DRAIN after a timeout.
  - Latency from a completion input at cycle M to the done pulse is cycle M+1.
  - The granted source's miss deasserts by the cycle after done. IDLE ignores a miss that is still high in the cycle immediately following RESPOND, so the same miss cannot be regranted.
- Flush:
  - flush_i in ISSUE, WAIT_START, or WALK goes to DRAIN; ptw_req_o is suppressed if in ISSUE, and no done pulse is issued.
  - flush_i in RESPOND still issues the done pulse, then goes to DRAIN.
  - flush_i in IDLE or DRAIN has no effect beyond blocking a grant that cycle.
- DRAIN:
  - Ignore completion inputs.
  - Go to IDLE on the first cycle with ptw_active_i = 0 and flush_i = 0.
- Never more than one walk outstanding.
- Never both done outputs in the same cycle.
- Counter is log2(TIMEOUT_CYCLES) bits and clears on entering WALK.

Test Plan:
1. Single ITLB miss:
   - Stimulus: itlb_miss_i=1, vaddr=0x40_0000_1000. Walker raises active 2 cycles after req and update_valid 10 cycles later.
   - Required: ptw_req_o one cycle after the miss, ptw_is_instr_o=1; itlb_done_o one cycle after update_valid; both faults 0; dtlb_done_o stays 0.
2. Simultaneous misses, repeated:
   - Stimulus: both misses high in the same cycle after reset; repeat after each completion.
   - Required: grant order ITLB, DTLB, ITLB, DTLB; each done pulse goes to the correct source; ptw_is_store_o follows dtlb_is_store_i=1.
3. Fault priority:
   - Stimulus: DTLB walk ends with ptw_error_i=1 and ptw_access_exception_i=1 in the same cycle.
   - Required: dtlb_done_o=1 with resp_access_fault_o=1 and resp_page_fault_o=0.
4. Flush mid-walk:
   - Stimulus: flush_i in WALK while ptw_active_i stays high 5 more cycles, then a new ITLB miss.
   - Required: no done pulse; busy_o=1 until active drops; the new ITLB miss is granted only after that.
5. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, walker active but never completes.
   - Required: done pulse with access fault 16 cycles after WALK entry; timeout_o stays 1; FSM remains in DRAIN until active drops.
6. Reset mid-walk:
   - Stimulus: rst_i pulsed for one cycle during WALK.
   - Required: all outputs 0 on the next cycle; no done pulse; first tie afterwards is granted to ITLB.

Source files
------------

// File: rtl/ptw_miss_arbiter.sv
// ptw_miss_arbiter
//   Shares one page-table walker between the ITLB and the DTLB. Held miss
//   requests are arbitrated round-robin. The winner's vaddr, ASID and store
//   flag are latched, and a single walk request is issued. The walker's
//   completion comes back to the originating TLB as a one-cycle done pulse
//   with fault flags. A flush drains the in-flight walk without a done pulse.
//   Each walk is bounded by TIMEOUT_CYCLES; an expired walk completes with an
//   access fault.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i                      pipeline flush
//   itlb_miss_i/itlb_vaddr_i     held ITLB miss request
//   dtlb_miss_i/dtlb_vaddr_i     held DTLB miss request
//   dtlb_is_store_i              DTLB miss caused by a store
//   asid_i                       current ASID
//   ptw_req_o                    one-cycle walk request
//   ptw_vaddr_o/ptw_asid_o       latched walk address / ASID
//   ptw_is_instr_o/ptw_is_store_o latched grant source / store flag
//   ptw_active_i                 walker busy
//   ptw_update_valid_i           walker produced a TLB update
//   ptw_error_i                  walker page fault
//   ptw_access_exception_i       walker PMP access fault
//   itlb_done_o/dtlb_done_o      completion pulses
//   resp_page_fault_o            page fault, valid with a done pulse
//   resp_access_fault_o          access fault, valid with a done pulse
//   timeout_o                    sticky timeout flag
//   busy_o                       arbiter not idle
module ptw_miss_arbiter #(
    parameter int VLEN           = 39,
    parameter int ASID_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  itlb_miss_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    input  logic                  dtlb_miss_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    input  logic                  dtlb_is_store_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    output logic                  ptw_req_o,
    output logic [VLEN-1:0]       ptw_vaddr_o,
    output logic [ASID_WIDTH-1:0] ptw_asid_o,
    output logic                  ptw_is_instr_o,
    output logic                  ptw_is_store_o,
    input  logic                  ptw_active_i,
    input  logic                  ptw_update_valid_i,
    input  logic                  ptw_error_i,
    input  logic                  ptw_access_exception_i,
    output logic                  itlb_done_o,
    output logic                  dtlb_done_o,
    output logic                  resp_page_fault_o,
    output logic                  resp_access_fault_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WALK,
        S_RESPOND,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [VLEN-1:0]       r_vaddr;
    logic [ASID_WIDTH-1:0] r_asid;
    logic                  r_is_instr;
    logic                  r_is_store;
    logic                  r_last_i;     // last grant went to the ITLB
    logic                  r_page_fault;
    logic                  r_access_fault;
    logic                  r_to_drain;   // timed-out walk must drain after RESPOND
    logic                  r_timeout;
    logic                  r_block;      // previous cycle was RESPOND

    logic w_any_cmpl;
    logic w_grant;
    logic w_grant_i;
    logic w_cmpl;
    logic w_expire;
    logic w_cnt_clr;

    assign w_any_cmpl = ptw_update_valid_i | ptw_error_i | ptw_access_exception_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_i   = 1'b0;
        w_cmpl      = 1'b0;
        w_expire    = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_block stops the miss that just completed from being granted again
                if (!flush_i && !r_block && (itlb_miss_i || dtlb_miss_i)) begin
                    w_grant     = 1'b1;
                    w_grant_i   = (itlb_miss_i && dtlb_miss_i) ? !r_last_i : itlb_miss_i;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = flush_i ? S_DRAIN : S_WAIT_START;
            end
            S_WAIT_START: begin
                if (flush_i) begin
                    w_state_nxt = S_DRAIN;
                end else if (ptw_active_i) begin
                    // a completion together with the start is handled as in WALK
                    if (w_any_cmpl) begin
                        w_cmpl      = 1'b1;
                        w_state_nxt = S_RESPOND;
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (flush_i) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_any_cmpl) begin
                    w_cmpl      = 1'b1;
                    w_state_nxt = S_RESPOND;
                end else if (r_cnt == CNT_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_state_nxt = (flush_i || r_to_drain) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!ptw_active_i && !flush_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt          <= '0;
            r_vaddr        <= '0;
            r_asid         <= '0;
            r_is_instr     <= 1'b0;
            r_is_store     <= 1'b0;
            r_last_i       <= 1'b0;
            r_page_fault   <= 1'b0;
            r_access_fault <= 1'b0;
            r_to_drain     <= 1'b0;
            r_timeout      <= 1'b0;
            r_block        <= 1'b0;
        end else begin
            r_block <= (r_state == S_RESPOND);

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state == S_WALK) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_grant) begin
                r_vaddr        <= w_grant_i ? itlb_vaddr_i : dtlb_vaddr_i;
                r_asid         <= asid_i;
                r_is_instr     <= w_grant_i;
                r_is_store     <= w_grant_i ? 1'b0 : dtlb_is_store_i;
                r_last_i       <= w_grant_i;
                r_page_fault   <= 1'b0;
                r_access_fault <= 1'b0;
            end

            // access fault dominates when several completion inputs coincide
            if (w_cmpl) begin
                r_page_fault   <= ptw_error_i & ~ptw_access_exception_i;
                r_access_fault <= ptw_access_exception_i;
            end

            if (w_expire) begin
                r_page_fault   <= 1'b0;
                r_access_fault <= 1'b1;
                r_to_drain     <= 1'b1;
                r_timeout      <= 1'b1;
            end else if (r_state == S_RESPOND) begin
                r_to_drain <= 1'b0;
            end
        end
    end

    assign ptw_req_o           = (r_state == S_ISSUE) && !flush_i;
    assign ptw_vaddr_o         = r_vaddr;
    assign ptw_asid_o          = r_asid;
    assign ptw_is_instr_o      = r_is_instr;
    assign ptw_is_store_o      = r_is_store;
    assign itlb_done_o         = (r_state == S_RESPOND) && r_is_instr;
    assign dtlb_done_o         = (r_state == S_RESPOND) && !r_is_instr;
    assign resp_page_fault_o   = (r_state == S_RESPOND) && r_page_fault;
    assign resp_access_fault_o = (r_state == S_RESPOND) && r_access_fault;
    assign timeout_o           = r_timeout;
    assign busy_o              = (r_state != S_IDLE);

endmodule

// File: tb/tb_ptw_miss_arbiter.sv
// Testbench for ptw_miss_arbiter: directed stimulus; expected walk requests
// and done responses are queued by the stimulus and checked by monitors.
module tb_ptw_miss_arbiter;

    localparam int VLEN = 39;
    localparam int AW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            itlb_miss = 1'b0;
    logic [VLEN-1:0] itlb_vaddr = '0;
    logic            dtlb_miss = 1'b0;
    logic [VLEN-1:0] dtlb_vaddr = '0;
    logic            dtlb_store = 1'b0;
    logic [AW-1:0]   asid = '0;
    logic            ptw_active = 1'b0;
    logic            ptw_upd = 1'b0;
    logic            ptw_err = 1'b0;
    logic            ptw_acc = 1'b0;

    logic            ptw_req_o;
    logic [VLEN-1:0] ptw_vaddr_o;
    logic [AW-1:0]   ptw_asid_o;
    logic            ptw_is_instr_o;
    logic            ptw_is_store_o;
    logic            itlb_done_o;
    logic            dtlb_done_o;
    logic            resp_page_fault_o;
    logic            resp_access_fault_o;
    logic            timeout_o;
    logic            busy_o;

    ptw_miss_arbiter #(
        .VLEN(VLEN), .ASID_WIDTH(AW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .itlb_miss_i(itlb_miss), .itlb_vaddr_i(itlb_vaddr),
        .dtlb_miss_i(dtlb_miss), .dtlb_vaddr_i(dtlb_vaddr),
        .dtlb_is_store_i(dtlb_store), .asid_i(asid),
        .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o), .ptw_asid_o(ptw_asid_o),
        .ptw_is_instr_o(ptw_is_instr_o), .ptw_is_store_o(ptw_is_store_o),
        .ptw_active_i(ptw_active), .ptw_update_valid_i(ptw_upd),
        .ptw_error_i(ptw_err), .ptw_access_exception_i(ptw_acc),
        .itlb_done_o(itlb_done_o), .dtlb_done_o(dtlb_done_o),
        .resp_page_fault_o(resp_page_fault_o), .resp_access_fault_o(resp_access_fault_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            instr;
        logic            store;
        logic [VLEN-1:0] vaddr;
        logic [AW-1:0]   asid;
    } req_t;

    typedef struct packed {
        logic instr;
        logic pf;
        logic af;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request monitor
    always @(negedge clk) begin
        if (ptw_req_o) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 64'(ptw_req_o), 64'd0);
            end else begin
                req_t e;
                e = req_q.pop_front();
                chk("req_fields", 64'({ptw_is_instr_o, ptw_is_store_o, ptw_vaddr_o, ptw_asid_o}), 64'(e));
            end
        end
    end

    // Done monitor
    always @(negedge clk) begin
        if (itlb_done_o || dtlb_done_o) begin
            chk("done_exclusive", 64'(itlb_done_o & dtlb_done_o), 64'd0);
            if (done_q.size() == 0) begin
                chk("unexpected_done", 64'({itlb_done_o, dtlb_done_o}), 64'd0);
            end else begin
                done_t e;
                e = done_q.pop_front();
                chk("done_resp",
                    64'({itlb_done_o, dtlb_done_o, resp_page_fault_o, resp_access_fault_o}),
                    64'({e.instr, ~e.instr, e.pf, e.af}));
            end
        end
    end

    task automatic exp_req(input logic instr, input logic store, input logic [VLEN-1:0] va,
                           input logic [AW-1:0] as);
        req_t r;
        r.instr = instr;
        r.store = store;
        r.vaddr = va;
        r.asid  = as;
        req_q.push_back(r);
    endtask

    // Advances from the post-completion IDLE cycle to the ISSUE cycle.
    task automatic wait_req();
        int n = 0;
        while (!ptw_req_o && n < 8) begin
            tick();
            n++;
        end
        chk("wait_req", 64'(ptw_req_o), 64'd1);
    endtask

    // Starts in the ISSUE cycle; ends in the cycle after RESPOND.
    task automatic run_walk(input int act_dly, input int len, input logic upd, input logic err,
                            input logic acc, input logic src_i, input logic e_pf, input logic e_af);
        done_t d;
        repeat (act_dly) tick();
        ptw_active = 1'b1;
        repeat (len) tick();
        ptw_upd = upd;
        ptw_err = err;
        ptw_acc = acc;
        d.instr = src_i;
        d.pf    = e_pf;
        d.af    = e_af;
        done_q.push_back(d);
        tick();
        chk("done_latency", 64'({itlb_done_o, dtlb_done_o}), src_i ? 64'd2 : 64'd1);
        ptw_upd    = 1'b0;
        ptw_err    = 1'b0;
        ptw_acc    = 1'b0;
        ptw_active = 1'b0;
        if (src_i) itlb_miss = 1'b0;
        else       dtlb_miss = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int n;
        asid = 16'hA5A5;
        do_reset();
        chk("reset_outputs",
            64'({ptw_req_o, itlb_done_o, dtlb_done_o, resp_page_fault_o,
                 resp_access_fault_o, timeout_o, busy_o, ptw_is_instr_o, ptw_is_store_o}), 64'd0);
        chk("reset_vaddr_asid", 64'({ptw_vaddr_o, ptw_asid_o}), 64'd0);

        // 1: single ITLB miss
        itlb_vaddr = 39'h40_0000_1000;
        itlb_miss  = 1'b1;
        exp_req(1'b1, 1'b0, 39'h40_0000_1000, 16'hA5A5);
        tick();
        chk("t1_req_latency", 64'(ptw_req_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        run_walk(2, 10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_idle_after", 64'({busy_o, itlb_done_o}), 64'd0);

        // 2: simultaneous misses alternate I, D, I, D
        do_reset();
        itlb_vaddr = 39'h00_1111_2000;
        dtlb_vaddr = 39'h00_2222_3000;
        dtlb_store = 1'b1;
        itlb_miss  = 1'b1;
        dtlb_miss  = 1'b1;
        exp_req(1'b1, 1'b0, 39'h00_1111_2000, 16'hA5A5);
        tick();
        chk("t2_first_tie_itlb", 64'({ptw_req_o, ptw_is_instr_o}), 64'd3);
        run_walk(2, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        itlb_vaddr = 39'h00_1111_4000;
        itlb_miss  = 1'b1;
        exp_req(1'b0, 1'b1, 39'h00_2222_3000, 16'hA5A5);
        wait_req();
        run_walk(1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dtlb_vaddr = 39'h00_2222_5000;
        dtlb_miss  = 1'b1;
        exp_req(1'b1, 1'b0, 39'h00_1111_4000, 16'hA5A5);
        wait_req();
        run_walk(2, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_req(1'b0, 1'b1, 39'h00_2222_5000, 16'hA5A5);
        wait_req();
        run_walk(2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: fault priority, completion arriving together with active
        dtlb_store = 1'b0;
        dtlb_vaddr = 39'h12_3456_7000;
        dtlb_miss  = 1'b1;
        exp_req(1'b0, 1'b0, 39'h12_3456_7000, 16'hA5A5);
        wait_req();
        run_walk(2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // 4: flush mid-walk
        dtlb_store = 1'b1;
        dtlb_vaddr = 39'h00_0000_8000;
        dtlb_miss  = 1'b1;
        exp_req(1'b0, 1'b1, 39'h00_0000_8000, 16'hA5A5);
        wait_req();
        repeat (2) tick();
        ptw_active = 1'b1;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        dtlb_miss  = 1'b0;
        itlb_vaddr = 39'h00_0000_9000;
        itlb_miss  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_drain_busy", 64'({busy_o, ptw_req_o}), 64'd2);
            tick();
        end
        ptw_active = 1'b0;
        exp_req(1'b1, 1'b0, 39'h00_0000_9000, 16'hA5A5);
        chk("t4_drain_last", 64'({busy_o, ptw_req_o}), 64'd2);
        tick();
        chk("t4_idle", 64'({busy_o, ptw_req_o}), 64'd0);
        tick();
        chk("t4_new_grant", 64'({ptw_req_o, ptw_is_instr_o}), 64'd3);
        run_walk(1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // 5: timeout after 16 WALK cycles
        dtlb_store = 1'b0;
        dtlb_vaddr = 39'h7F_FFFF_F000;
        dtlb_miss  = 1'b1;
        exp_req(1'b0, 1'b0, 39'h7F_FFFF_F000, 16'hA5A5);
        wait_req();
        chk("t5_timeout_clear", 64'(timeout_o), 64'd0);
        repeat (2) tick();
        ptw_active = 1'b1;
        done_q.push_back(3'b001);
        tick();
        n = 0;
        while (!dtlb_done_o && n < 40) begin
            tick();
            n++;
        end
        chk("t5_timeout_latency", 64'(n), 64'd16);
        chk("t5_timeout_set", 64'(timeout_o), 64'd1);
        dtlb_miss = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t5_drain", 64'({busy_o, timeout_o, dtlb_done_o}), 64'd6);
            tick();
        end
        ptw_active = 1'b0;
        tick();
        chk("t5_idle_sticky", 64'({busy_o, timeout_o}), 64'd1);

        // 6: reset mid-walk
        asid       = 16'h1234;
        itlb_vaddr = 39'h01_0000_0000;
        itlb_miss  = 1'b1;
        exp_req(1'b1, 1'b0, 39'h01_0000_0000, 16'h1234);
        wait_req();
        repeat (2) tick();
        ptw_active = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        ptw_active = 1'b0;
        chk("t6_outputs_zero",
            64'({ptw_req_o, itlb_done_o, dtlb_done_o, resp_page_fault_o,
                 resp_access_fault_o, timeout_o, busy_o, ptw_is_instr_o, ptw_is_store_o}), 64'd0);
        chk("t6_latched_zero", 64'({ptw_vaddr_o, ptw_asid_o}), 64'd0);
        itlb_vaddr = 39'h02_0000_0000;
        dtlb_vaddr = 39'h03_0000_0000;
        dtlb_store = 1'b1;
        dtlb_miss  = 1'b1;
        exp_req(1'b1, 1'b0, 39'h02_0000_0000, 16'h1234);
        tick();
        chk("t6_tie_itlb", 64'({ptw_req_o, ptw_is_instr_o}), 64'd3);
        run_walk(2, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        dtlb_miss = 1'b0;
        repeat (3) tick();

        chk("req_queue_empty", 64'(req_q.size()), 64'd0);
        chk("done_queue_empty", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
